board_change_detector: RTL and testbench

Consumes the 32-bit square-occupancy snapshots produced by the shift-register sensor reader, one per completed scan. It debounces them over consecutive identical scans and holds the committed stable board. On each committed change it emits per-square lifted/placed events, ascending by square index, into a small FIFO that the CPU drains. It sits between the sensor reader and the CPU's memory-mapped input logic.

---
 rtl/board_change_detector.sv | 148 ++++++++++++++
 tb/tb_board_change_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/board_change_detector.sv
// Debounces 32-square occupancy scans, holds the committed board, and queues
// per-square lifted/placed events (ascending square order) in a FWFT FIFO.
module board_change_detector #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_AW        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        scan_data,
    input  logic               scan_valid,
    output logic [31:0]        stable_board,
    output logic               board_valid,
    output logic               evt_valid,
    output logic [5:0]         evt_data,
    input  logic               evt_ready,
    output logic [FIFO_AW:0]   evt_count,
    output logic               overflow,
    input  logic               clear_overflow,
    output logic               busy
);

    localparam logic [3:0]         DEB   = 4'(DEBOUNCE_SCANS);
    localparam logic [FIFO_AW:0]   DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q;
    logic [31:0]         cand_q, cand_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         stable_q;
    logic                board_valid_q;
    logic [31:0]         diff_q;
    logic [4:0]          idx_q;
    logic                busy_q;

    logic [5:0]          mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    logic                push_vld, pop, full, push_ok;
    logic [5:0]          push_dat;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (scan_valid) begin
            if (scan_data == cand_q) begin
                if (cnt_q != DEB) cnt_d = cnt_q + 4'd1;
            end else begin
                cand_d = scan_data;
                cnt_d  = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Commit is only examined in IDLE, so a change settling mid-SCAN waits its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            stable_q      <= '0;
            board_valid_q <= 1'b0;
            diff_q        <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q == DEB && (!board_valid_q || cand_q != stable_q)) begin
                        stable_q <= cand_q;
                        if (!board_valid_q) begin
                            board_valid_q <= 1'b1;
                        end else begin
                            diff_q  <= cand_q ^ stable_q;
                            idx_q   <= '0;
                            state_q <= SCAN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // stable_q already holds the new board, so its bit is the placed flag.
    assign push_vld = (state_q == SCAN) && diff_q[idx_q];
    assign push_dat = {stable_q[idx_q], idx_q};

    assign full    = (count_q == DEPTH);
    assign pop     = evt_ready && (count_q != '0);
    assign push_ok = push_vld && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = (overflow_q && !clear_overflow) || (push_vld && full && !pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

    assign stable_board = stable_q;
    assign board_valid  = board_valid_q;
    assign evt_valid    = (count_q != '0);
    assign evt_data     = mem_q[rd_ptr_q];
    assign evt_count    = count_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_board_change_detector.sv
// Directed bench for board_change_detector: events checked through a scoreboard
// queue popped by a monitor on each accepted FIFO head.
module tb_board_change_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] scan_data = '0;
    logic        scan_valid = 1'b0;
    logic [31:0] stable_board;
    logic        board_valid;
    logic        evt_valid;
    logic [5:0]  evt_data;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_count;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    logic [5:0] exp_q[$];

    board_change_detector #(.DEBOUNCE_SCANS(4), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
        .stable_board(stable_board), .board_valid(board_valid),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_count(evt_count), .overflow(overflow), .clear_overflow(clear_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [5:0] e;
        if (busy) busy_cycles++;
        if (!reset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got 0x%0h, none expected", evt_data);
            end else begin
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL evt_data: got 0x%0h expected 0x%0h", evt_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic scan(input logic [31:0] d);
        @(posedge clk); #1;
        scan_data  = d;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic scan4(input logic [31:0] d);
        for (int i = 0; i < 4; i++) scan(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_stable", stable_board, 32'h0);
        chk("rst_board_valid", board_valid, 1'b0);
        chk("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_evt_count", evt_count, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // 1: first commit is silent
        busy_cycles = 0;
        scan4(32'h0000_0FFF);
        @(posedge clk); #1;
        chk("t1_stable", stable_board, 32'h0000_0FFF);
        chk("t1_board_valid", board_valid, 1'b1);
        chk("t1_evt_valid", evt_valid, 1'b0);
        scan(32'h0000_0FFF);
        scan(32'h0000_0FFF);
        repeat (3) @(posedge clk); #1;
        chk("t1_busy_cycles", busy_cycles, 0);
        chk("t1_sat_evt_valid", evt_valid, 1'b0);

        // 2: bouncing scans never commit
        for (int i = 0; i < 6; i++) scan(i[0] ? 32'h0000_0FFF : 32'h0000_0FFE);
        repeat (5) @(posedge clk); #1;
        chk("t2_stable", stable_board, 32'h0000_0FFF);
        chk("t2_evt_valid", evt_valid, 1'b0);
        chk("t2_busy_cycles", busy_cycles, 0);

        // 3: lifted sq0, placed sq20
        evt_ready = 1'b1;
        exp_q.push_back(6'b000000);
        exp_q.push_back(6'b110100);
        scan4(32'h0010_0FFE);
        repeat (40) @(posedge clk); #1;
        chk("t3_busy_cycles", busy_cycles, 32);
        chk("t3_stable", stable_board, 32'h0010_0FFE);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_evt_count", evt_count, 4'd0);

        // 4: 12 changes into an 8-deep FIFO with no draining
        evt_ready = 1'b0;
        exp_q.push_back(6'h20);
        for (int k = 1; k < 8; k++) exp_q.push_back(6'(k));
        scan4(32'h0010_0001);
        repeat (40) @(posedge clk); #1;
        chk("t4_evt_count_full", evt_count, 4'd8);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_head", evt_data, 6'h20);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        evt_ready = 1'b0;
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_evt_count_empty", evt_count, 4'd0);
        chk("t4_overflow_sticky", overflow, 1'b1);
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        chk("t4_overflow_clr", overflow, 1'b0);

        // 5: full FIFO, push of sq20 coincides with a pop
        exp_q.push_back(6'h00);
        for (int k = 1; k < 8; k++) exp_q.push_back(6'(32 + k));
        exp_q.push_back(6'h14);
        scan4(32'h0000_00FE);
        @(posedge clk); #1;
        chk("t5_busy_start", busy, 1'b1);
        repeat (20) @(posedge clk); #1;
        chk("t5_full_before", evt_count, 4'd8);
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        chk("t5_count_kept", evt_count, 4'd8);
        chk("t5_no_overflow", overflow, 1'b0);
        evt_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        evt_ready = 1'b0;
        chk("t5_sb_empty", exp_q.size(), 0);
        chk("t5_stable", stable_board, 32'h0000_00FE);

        // 6: reset mid-SCAN discards everything
        scan4(32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("t6_busy_start", busy, 1'b1);
        repeat (10) @(posedge clk); #1;
        chk("t6_events_queued", evt_valid, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_evt_valid", evt_valid, 1'b0);
        chk("t6_evt_count", evt_count, 4'd0);
        chk("t6_stable", stable_board, 32'h0);
        chk("t6_board_valid", board_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        busy_cycles = 0;
        scan4(32'h1234_5678);
        @(posedge clk); #1;
        chk("t6_recommit", stable_board, 32'h1234_5678);
        chk("t6_board_valid2", board_valid, 1'b1);
        repeat (5) @(posedge clk); #1;
        chk("t6_silent", evt_valid, 1'b0);
        chk("t6_busy_cycles", busy_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
